// File: rtl/s_to_p_if.sv
// Serial-in / word-out bundle for the s_to_p deserializer.
// The slave side is the deserializer; the master side feeds bits and drains words.
interface s_to_p_if #(
    parameter int WIDTH = 4
);
    logic             din;
    logic             din_valid;
    logic             sof;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             frame_err;
    logic             overrun;
    logic             ovr_clr;

    modport master (
        output din, din_valid, sof, dout_ready, ovr_clr,
        input  dout, dout_valid, frame_err, overrun
    );

    modport slave (
        input  din, din_valid, sof, dout_ready, ovr_clr,
        output dout, dout_valid, frame_err, overrun
    );
endinterface

// File: rtl/s_to_p.sv
// Serial-to-parallel deserializer: rebuilds WIDTH-bit words from a strobed bit stream,
// holds each in a single-entry valid/ready register, and flags early-sof and overrun.
module s_to_p #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input logic     clk,
    input logic     rst,
    s_to_p_if.slave bus
);
    localparam int             CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {HUNT, ASSEMBLE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [WIDTH-1:0] dout_q;
    logic             dout_valid_q, frame_err_q, overrun_q;

    logic             start_word, shift_bit, early_sof;
    logic [CW-1:0]    idx, pos;
    logic [WIDTH-1:0] mask, base, word_nxt;
    logic             word_done, load, drop;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= HUNT;
        else     state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            HUNT:     if (bus.din_valid && bus.sof) state_nxt = ASSEMBLE;
            ASSEMBLE: state_nxt = ASSEMBLE;
            default:  state_nxt = HUNT;
        endcase
    end

    always_comb begin
        start_word = 1'b0;
        shift_bit  = 1'b0;
        early_sof  = 1'b0;
        case (state)
            HUNT: start_word = bus.din_valid && bus.sof;
            ASSEMBLE: begin
                start_word = bus.din_valid && bus.sof;
                shift_bit  = bus.din_valid && !bus.sof;
                early_sof  = bus.din_valid && bus.sof && (count != '0);
            end
            default: ;
        endcase
    end

    // A sof always restarts the word at bit 0, discarding any partial contents.
    always_comb begin
        idx       = start_word ? '0 : count;
        pos       = LSB_FIRST ? idx : (LAST_IDX - idx);
        mask      = ONE << pos;
        base      = (idx == '0) ? '0 : shreg;
        word_nxt  = (base & ~mask) | ({WIDTH{bus.din}} & mask);
        word_done = shift_bit && (count == LAST_IDX);
        load      = word_done && (!dout_valid_q || bus.dout_ready);
        drop      = word_done && !load;

        count_nxt = count;
        shreg_nxt = shreg;
        if (start_word) begin
            count_nxt = CW'(1);
            shreg_nxt = word_nxt;
        end else if (shift_bit) begin
            count_nxt = word_done ? '0 : count + CW'(1);
            shreg_nxt = word_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= '0;
            shreg        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            count       <= count_nxt;
            shreg       <= shreg_nxt;
            frame_err_q <= early_sof;

            if (load) begin
                dout_q       <= word_nxt;
                dout_valid_q <= 1'b1;
            end else if (dout_valid_q && bus.dout_ready) begin
                dout_valid_q <= 1'b0;
            end

            // A drop in the same cycle as ovr_clr keeps the flag set.
            if (drop)             overrun_q <= 1'b1;
            else if (bus.ovr_clr) overrun_q <= 1'b0;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_s_to_p.sv
// Scoreboard bench for s_to_p: LSB-first and MSB-first instances share one stimulus stream
// and are checked against a bit-list reference model.
module tb_s_to_p;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic din = 1'b0, din_valid = 1'b0, sof = 1'b0, dout_ready = 1'b0, ovr_clr = 1'b0;

    always #5 clk = ~clk;

    s_to_p_if #(.WIDTH(W)) lsb_if ();
    s_to_p_if #(.WIDTH(W)) msb_if ();

    assign lsb_if.din        = din;
    assign lsb_if.din_valid  = din_valid;
    assign lsb_if.sof        = sof;
    assign lsb_if.dout_ready = dout_ready;
    assign lsb_if.ovr_clr    = ovr_clr;
    assign msb_if.din        = din;
    assign msb_if.din_valid  = din_valid;
    assign msb_if.sof        = sof;
    assign msb_if.dout_ready = dout_ready;
    assign msb_if.ovr_clr    = ovr_clr;

    s_to_p #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (.clk(clk), .rst(rst), .bus(lsb_if));
    s_to_p #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (.clk(clk), .rst(rst), .bus(msb_if));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: the bits of the word in progress, plus the output-register view.
    bit             m_hunt = 1'b1;
    bit             m_bits[$];
    bit             m_valid = 1'b0, m_ovr = 1'b0, m_fe = 1'b0;
    logic [W-1:0]   q_lsb[$], q_msb[$];

    function automatic logic [W-1:0] pack_word(input bit lsb);
        int acc = 0;
        for (int i = 0; i < W; i++)
            if (m_bits[i]) acc += lsb ? (1 << i) : (1 << (W - 1 - i));
        return acc[W-1:0];
    endfunction

    task automatic model_reset();
        m_hunt = 1'b1; m_bits.delete();
        m_valid = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
        q_lsb.delete(); q_msb.delete();
    endtask

    task automatic model_update(input bit d, input bit v, input bit s, input bit r, input bit c);
        bit           done = 1'b0;
        bit           drop;
        logic [W-1:0] w_l = '0, w_m = '0;
        m_fe = 1'b0;
        if (v) begin
            if (s) begin
                if (!m_hunt && m_bits.size() != 0) m_fe = 1'b1;
                m_bits.delete();
                m_bits.push_back(d);
                m_hunt = 1'b0;
            end else if (!m_hunt) begin
                m_bits.push_back(d);
                if (m_bits.size() == W) begin
                    done = 1'b1;
                    w_l  = pack_word(1'b1);
                    w_m  = pack_word(1'b0);
                    m_bits.delete();
                end
            end
        end
        drop = done && m_valid && !r;
        if (done && !drop) begin
            q_lsb.push_back(w_l);
            q_msb.push_back(w_m);
            m_valid = 1'b1;
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
        if (drop)   m_ovr = 1'b1;
        else if (c) m_ovr = 1'b0;
    endtask

    // Monitor: flags every cycle, data on each accepted handshake.
    always @(negedge clk) begin
        if (!rst) begin
            check("lsb_valid",   32'(lsb_if.dout_valid), 32'(m_valid));
            check("msb_valid",   32'(msb_if.dout_valid), 32'(m_valid));
            check("lsb_frame",   32'(lsb_if.frame_err),  32'(m_fe));
            check("msb_frame",   32'(msb_if.frame_err),  32'(m_fe));
            check("lsb_overrun", 32'(lsb_if.overrun),    32'(m_ovr));
            check("msb_overrun", 32'(msb_if.overrun),    32'(m_ovr));
            if (lsb_if.dout_valid && dout_ready) begin
                check("lsb_pending", 32'(q_lsb.size() != 0), 32'd1);
                if (q_lsb.size() != 0) check("lsb_dout", 32'(lsb_if.dout), 32'(q_lsb.pop_front()));
            end
            if (msb_if.dout_valid && dout_ready) begin
                check("msb_pending", 32'(q_msb.size() != 0), 32'd1);
                if (q_msb.size() != 0) check("msb_dout", 32'(msb_if.dout), 32'(q_msb.pop_front()));
            end
        end
    end

    task automatic step(input bit d, input bit v, input bit s, input bit r, input bit c);
        din = d; din_valid = v; sof = s; dout_ready = r; ovr_clr = c;
        @(posedge clk);
        model_update(d, v, s, r, c);
        #1;
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, r, 1'b0);
    endtask

    // bits[i] is the i-th serial bit; the first carries sof.
    task automatic send(input bit [W-1:0] bits, input bit r, input int gap);
        for (int i = 0; i < W; i++) begin
            step(bits[i], 1'b1, i == 0, r, 1'b0);
            if (i != W - 1) idle(gap, r);
        end
    endtask

    task automatic reset_dut();
        din_valid = 1'b0; sof = 1'b0; ovr_clr = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_lsb_dout",  32'(lsb_if.dout),       32'd0);
        check("rst_lsb_valid", 32'(lsb_if.dout_valid), 32'd0);
        check("rst_lsb_frame", 32'(lsb_if.frame_err),  32'd0);
        check("rst_lsb_ovr",   32'(lsb_if.overrun),    32'd0);
        check("rst_msb_dout",  32'(msb_if.dout),       32'd0);
        check("rst_msb_valid", 32'(msb_if.dout_valid), 32'd0);
        check("rst_msb_frame", 32'(msb_if.frame_err),  32'd0);
        check("rst_msb_ovr",   32'(msb_if.overrun),    32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2;
        reset_dut();

        // Serial 1,0,1,1 -> LSB word D, MSB word B; valid for one cycle.
        send(4'b1101, 1'b1, 0);
        check("tp1_dout",  32'(lsb_if.dout), 32'hD);
        check("tp1_msb",   32'(msb_if.dout), 32'hB);
        check("tp1_valid", 32'(lsb_if.dout_valid), 32'd1);
        idle(1, 1'b1);
        check("tp1_valid_drop", 32'(lsb_if.dout_valid), 32'd0);

        // Bits before the first sof are ignored.
        reset_dut();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("tp2_no_word", 32'(lsb_if.dout_valid), 32'd0);
        send(4'b0010, 1'b1, 0);
        check("tp2_dout", 32'(lsb_if.dout), 32'h2);
        check("tp2_msb",  32'(msb_if.dout), 32'h4);
        idle(1, 1'b1);

        // MSB-first 1,0,0,0 -> 8, back-to-back and with 2-cycle gaps.
        send(4'b0001, 1'b1, 0);
        check("tp3_msb", 32'(msb_if.dout), 32'h8);
        idle(2, 1'b1);
        send(4'b0001, 1'b1, 2);
        check("tp3_gap_msb",   32'(msb_if.dout), 32'h8);
        check("tp3_gap_valid", 32'(msb_if.dout_valid), 32'd1);
        idle(1, 1'b1);

        // Early sof after two bits: one frame_err pulse, only A delivered.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("tp4_frame_err", 32'(lsb_if.frame_err), 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("tp4_frame_once", 32'(lsb_if.frame_err), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("tp4_dout", 32'(lsb_if.dout), 32'hA);
        check("tp4_msb",  32'(msb_if.dout), 32'h5);
        idle(1, 1'b1);

        // Output stalled: second word dropped, overrun sticky until cleared.
        send(4'b0011, 1'b0, 0);
        send(4'b0101, 1'b0, 0);
        check("tp5_dout_held", 32'(lsb_if.dout), 32'h3);
        check("tp5_overrun",   32'(lsb_if.overrun), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("tp5_ovr_clr", 32'(lsb_if.overrun), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("tp5_drained", 32'(lsb_if.dout_valid), 32'd0);

        // Reset mid-word loses the partial word.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        reset_dut();
        send(4'b0110, 1'b1, 0);
        check("tp6_dout", 32'(lsb_if.dout), 32'h6);
        idle(2, 1'b1);

        // Randomized traffic with gaps, stray sofs, stalls and clears.
        for (int n = 0; n < 3000; n++)
            step(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
        idle(4, 1'b1);
        check("queues_empty", 32'(q_lsb.size() + q_msb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/s_to_p.md
# s_to_p

Serial-to-parallel deserializer sitting directly downstream of the 4-bit parallel-to-serial converter. It consumes the 1-bit serial stream plus a per-bit strobe and a start-of-frame marker, reassembles WIDTH-bit words, and presents each word on a single-entry valid/ready output register. It also flags framing errors (premature start-of-frame) and overruns (output not drained in time).

## Interface

Parameters:
- WIDTH, 4: word width in bits; legal range 2..32.
- LSB_FIRST, 1: 1 = first serial bit of a word lands in dout[0]; 0 = first bit lands in dout[WIDTH-1].

Ports (one clock; reset asynchronous, active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- din  in  1  serial data bit.
- din_valid  in  1  din is a valid bit this cycle.
- sof  in  1  start of frame; qualified by din_valid; marks din as bit 0 of a word.
- dout  out  WIDTH  assembled word; stable while dout_valid=1 and dout_ready=0.
- dout_valid  out  1  dout holds an undelivered word.
- dout_ready  in  1  consumer accepts dout when dout_valid=1.
- frame_err  out  1  one-cycle pulse: partial word discarded by an early sof.
- overrun  out  1  sticky: a completed word was dropped because the output register was full.
- ovr_clr  in  1  clears overrun.

## Operation

- Reset values: dout=0, dout_valid=0, frame_err=0, overrun=0, bit counter=0, state=HUNT, shift register=0.
- States:
  - HUNT: bits with din_valid=1 and sof=0 are discarded. din_valid=1 and sof=1 stores the bit as bit 0, sets count=1, and moves to ASSEMBLE.
  - ASSEMBLE: each din_valid=1 stores din at index count (LSB_FIRST=1) or at WIDTH-1-count (LSB_FIRST=0), then increments count.
    - When count reaches WIDTH, the word is complete. Count returns to 0 and the state stays ASSEMBLE: the next word follows contiguously, and sof on its first bit is optional.
- Early sof: in ASSEMBLE with count≠0, din_valid=1 and sof=1 does the following:
  - frame_err=1 for the following cycle.
  - The partial word is discarded.
  - The current bit is stored as bit 0 and count=1.
  - sof at count=0 is not an error.
- sof with din_valid=0 is ignored.
- din_valid=0 cycles (gaps) hold all state and are legal anywhere.
- Output register:
  - A completed word loads into dout and sets dout_valid=1 if dout_valid=0, or if dout_valid=1 and dout_ready=1 in the same cycle (back-to-back delivery, no bubble).
  - Otherwise the word is dropped, overrun is set, and dout/dout_valid are unchanged.
  - dout_valid=1 and dout_ready=1 with no new word clears dout_valid; dout keeps its last value.
- overrun is cleared by ovr_clr=1. If a set and ovr_clr occur in the same cycle, the set wins.
- Counter width: $clog2(WIDTH)+1 bits. There is no wrap beyond WIDTH; the counter resets to 0 on completion.

## Timing

- Latency: last bit sampled at edge N, so dout/dout_valid are valid after edge N (visible in cycle N+1). The fastest rate is one word per WIDTH cycles.
- frame_err is asserted in the cycle after the offending sof, for exactly one cycle.
- overrun rises in the cycle after the dropped word's last bit.
- All outputs are registered. There is no combinational path from inputs to outputs.
- rst asserted mid-word or mid-handshake: immediate asynchronous return to the reset values, and the partial word is lost. After deassertion the block is in HUNT and needs a sof.
- An upstream 4-bit converter (LSB first, continuous) connects with WIDTH=4, LSB_FIRST=1, and din_valid tied to 1. sof is driven on the first bit of the upstream 4-bit cycle.

## Test plan

- WIDTH=4, LSB_FIRST=1, dout_ready=1: sof+din=1, then din 0,1,1 on consecutive cycles -> dout=4'hD, dout_valid=1 for exactly one cycle after the 4th bit; frame_err=0, overrun=0.
- After reset, 3 bits without sof, then sof + bits 0,1,0,0 -> single word dout=4'h2; the first 3 bits are ignored.
- LSB_FIRST=0: sof + bits 1,0,0,0 -> dout=4'h8. Repeat with din_valid gaps of 2 cycles between bits -> same result, with latency measured from the last bit.
- sof + bits 1,1, then sof + bits 0,1,0,1 -> frame_err pulses once after the 2nd sof; only dout=4'hA is delivered.
- dout_ready=0, two complete words 4'h3 then 4'h5 -> dout stays 4'h3, overrun=1. Pulse ovr_clr -> overrun=0. Raise dout_ready -> 4'h3 is delivered, then dout_valid=0.
- Assert rst after 2 bits of a word, release, then send sof + 4 bits for 4'h6 -> only 4'h6 is output; all outputs read 0 during reset.
